// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase arbiter: phase encoding,
// service identities and the round-robin service order.
package traffic_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    PH_STARTUP   = 3'd0,
    PH_ALL_RED   = 3'd1,
    PH_NS_GREEN  = 3'd2,
    PH_NS_YELLOW = 3'd3,
    PH_EW_GREEN  = 3'd4,
    PH_EW_YELLOW = 3'd5,
    PH_PED_WALK  = 3'd6
  } phase_e;

  // Service identities double as bit positions in the pending vector {ped, ew, ns}.
  typedef enum logic [1:0] {
    SRV_NS  = 2'd0,
    SRV_EW  = 2'd1,
    SRV_PED = 2'd2
  } service_e;

  function automatic service_e rr_succ(input service_e s);
    case (s)
      SRV_NS:  rr_succ = SRV_EW;
      SRV_EW:  rr_succ = SRV_PED;
      default: rr_succ = SRV_NS;
    endcase
  endfunction

  // First pending service strictly after the last one served; NS when idle.
  function automatic service_e rr_next(input logic [2:0] pend, input service_e last);
    service_e c1, c2, c3;
    c1 = rr_succ(last);
    c2 = rr_succ(c1);
    c3 = rr_succ(c2);
    if (pend[c1])      rr_next = c1;
    else if (pend[c2]) rr_next = c2;
    else if (pend[c3]) rr_next = c3;
    else               rr_next = SRV_NS;
  endfunction

  function automatic phase_e green_of(input service_e s);
    case (s)
      SRV_NS:  green_of = PH_NS_GREEN;
      SRV_EW:  green_of = PH_EW_GREEN;
      default: green_of = PH_PED_WALK;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-driven down counter: load wins over counting, done flags the tick
// on which the current interval's last count is consumed.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RESET_VAL = TIMER_W'(1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  logic [TIMER_W-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (tick && (count_q != '0))
      count_d = count_q - TIMER_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= RESET_VAL;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign done  = tick && (count_q == TIMER_W'(1));

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Two-road intersection controller with pedestrian phase: round-robin
// service of latched requests, min/max green, yellow and all-red clearance.
module intersection_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int STARTUP_TIME = 15,
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 60,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 3,
  parameter int WALK_TIME    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       req_ped,
  output logic       ns_green,
  output logic       ns_yellow,
  output logic       ns_red,
  output logic       ew_green,
  output logic       ew_yellow,
  output logic       ew_red,
  output logic       ped_walk,
  output logic [2:0] phase,
  output logic [2:0] pending
);

  if (STARTUP_TIME < 1 || STARTUP_TIME > 255 || MIN_GREEN < 1 || MIN_GREEN > 255 ||
      MAX_GREEN < 1 || MAX_GREEN > 255 || YELLOW_TIME < 1 || YELLOW_TIME > 255 ||
      ALL_RED_TIME < 1 || ALL_RED_TIME > 255 || WALK_TIME < 1 || WALK_TIME > 255 ||
      MIN_GREEN > MAX_GREEN) begin : g_param_check
    $error("intersection_phase_arbiter: timing parameters must be 1..255 with MIN_GREEN <= MAX_GREEN");
  end

  localparam logic [TIMER_W-1:0] T_STARTUP = TIMER_W'(STARTUP_TIME);
  localparam logic [TIMER_W-1:0] T_MAX     = TIMER_W'(MAX_GREEN);
  localparam logic [TIMER_W-1:0] T_YELLOW  = TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] T_ALL_RED = TIMER_W'(ALL_RED_TIME);
  localparam logic [TIMER_W-1:0] T_WALK    = TIMER_W'(WALK_TIME);

  phase_e             state_q, state_d;
  service_e           last_q, last_d;
  logic [2:0]         pending_q, pending_d;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_done;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic [TIMER_W:0]   elapsed_next;
  logic               min_reached;

  // Greens load MAX_GREEN, so elapsed ticks are recovered from the remaining count.
  function automatic logic [TIMER_W-1:0] duration(input phase_e ph);
    case (ph)
      PH_STARTUP:                duration = T_STARTUP;
      PH_NS_GREEN, PH_EW_GREEN:  duration = T_MAX;
      PH_NS_YELLOW, PH_EW_YELLOW: duration = T_YELLOW;
      PH_PED_WALK:               duration = T_WALK;
      default:                   duration = T_ALL_RED;
    endcase
  endfunction

  phase_timer #(
    .RESET_VAL(T_STARTUP)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (timer_load),
    .load_val (timer_load_val),
    .count    (timer_count),
    .done     (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    elapsed_next = (TIMER_W + 1)'(MAX_GREEN) - {1'b0, timer_count} + (TIMER_W + 1)'(1);
    min_reached  = tick && (elapsed_next >= (TIMER_W + 1)'(MIN_GREEN));
    case (state_q)
      PH_STARTUP:   if (timer_done) state_d = PH_ALL_RED;
      PH_ALL_RED: begin
        if (timer_done) begin
          last_d  = rr_next(pending_q, last_q);
          state_d = green_of(last_d);
        end
      end
      PH_NS_GREEN:
        if (timer_done || (min_reached && (pending_q[SRV_EW] || pending_q[SRV_PED])))
          state_d = PH_NS_YELLOW;
      PH_EW_GREEN:
        if (timer_done || (min_reached && (pending_q[SRV_NS] || pending_q[SRV_PED])))
          state_d = PH_EW_YELLOW;
      PH_NS_YELLOW, PH_EW_YELLOW, PH_PED_WALK:
        if (timer_done) state_d = PH_ALL_RED;
      default:      state_d = PH_ALL_RED;
    endcase

    timer_load     = (state_d != state_q);
    timer_load_val = duration(state_d);

    // A request for the phase being entered or already running is absorbed.
    pending_d[SRV_NS]  = (state_d == PH_NS_GREEN) ? 1'b0 : (pending_q[SRV_NS]  | req_ns);
    pending_d[SRV_EW]  = (state_d == PH_EW_GREEN) ? 1'b0 : (pending_q[SRV_EW]  | req_ew);
    pending_d[SRV_PED] = (state_d == PH_PED_WALK) ? 1'b0 : (pending_q[SRV_PED] | req_ped);
  end

  // NOTE: the asynchronous reset clears every control flop, not only the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PH_STARTUP;
      last_q    <= SRV_PED;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    ns_green  = 1'b0;
    ns_yellow = 1'b0;
    ew_green  = 1'b0;
    ew_yellow = 1'b0;
    ped_walk  = 1'b0;
    case (state_q)
      PH_NS_GREEN:  ns_green  = 1'b1;
      PH_NS_YELLOW: ns_yellow = 1'b1;
      PH_EW_GREEN:  ew_green  = 1'b1;
      PH_EW_YELLOW: ew_yellow = 1'b1;
      PH_PED_WALK:  ped_walk  = 1'b1;
      default:      ;
    endcase
    ns_red = !(ns_green || ns_yellow);
    ew_red = !(ew_green || ew_yellow);
  end

  assign phase   = state_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Directed bench for intersection_phase_arbiter with short timing parameters
// and tick asserted every cycle except during the freeze scenario.
module tb_intersection_phase_arbiter;

  localparam logic [2:0] P_SU  = 3'd0;
  localparam logic [2:0] P_AR  = 3'd1;
  localparam logic [2:0] P_NSG = 3'd2;
  localparam logic [2:0] P_NSY = 3'd3;
  localparam logic [2:0] P_EWG = 3'd4;
  localparam logic [2:0] P_EWY = 3'd5;
  localparam logic [2:0] P_PED = 3'd6;

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  localparam logic [6:0] L_ALLRED = 7'b0010010;
  localparam logic [6:0] L_NSG    = 7'b1000010;
  localparam logic [6:0] L_EWG    = 7'b0011000;

  logic       clk = 1'b0;
  logic       reset, tick, req_ns, req_ew, req_ped;
  logic       ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, ped_walk;
  logic [2:0] phase, pending;

  int checks = 0;
  int errors = 0;

  intersection_phase_arbiter #(
    .STARTUP_TIME(3), .MIN_GREEN(2), .MAX_GREEN(5),
    .YELLOW_TIME(2), .ALL_RED_TIME(1), .WALK_TIME(3)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .req_ns(req_ns), .req_ew(req_ew), .req_ped(req_ped),
    .ns_green(ns_green), .ns_yellow(ns_yellow), .ns_red(ns_red),
    .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red),
    .ped_walk(ped_walk), .phase(phase), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] lights();
    return {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, ped_walk};
  endfunction

  // Called at a negedge; returns at the first negedge showing a different phase.
  task automatic measure_run(output logic [2:0] ph, output int len, output int walk_cnt);
    ph = phase;
    len = 0;
    walk_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (phase !== ph) break;
      len++;
      if (ped_walk === 1'b1) walk_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (lights() !== L_ALLRED) begin
      errors++; $display("FAIL reset_lights: got %b want %b", lights(), L_ALLRED);
    end
    checks++;
    if (phase !== P_SU) begin
      errors++; $display("FAIL reset_phase: got %0d want %0d", phase, P_SU);
    end
    checks++;
    if (pending !== 3'b000) begin
      errors++; $display("FAIL reset_pending: got %b want 000", pending);
    end
    reset = 1'b0;
  endtask

  task automatic test_no_requests();
    logic [2:0] eph [5] = '{P_SU, P_AR, P_NSG, P_NSY, P_AR};
    int         elen[5] = '{3, 1, 5, 2, 1};
    logic [2:0] ph;
    int         len, wc;
    for (int i = 0; i < 5; i++) begin
      measure_run(ph, len, wc);
      checks++;
      if (ph !== eph[i] || len !== elen[i]) begin
        errors++;
        $display("FAIL idle_seq[%0d]: got phase %0d for %0d cycles, want phase %0d for %0d",
                 i, ph, len, eph[i], elen[i]);
      end
    end
    checks++;
    if (phase !== P_NSG || lights() !== L_NSG) begin
      errors++;
      $display("FAIL idle_return_ns: got phase %0d lights %b, want %0d %b", phase, lights(), P_NSG, L_NSG);
    end
  endtask

  task automatic test_all_requests();
    logic [2:0] eph [10] = '{P_SU, P_AR, P_NSG, P_NSY, P_AR, P_EWG, P_EWY, P_AR, P_PED, P_AR};
    int         elen[10] = '{3, 1, 2, 2, 1, 2, 2, 1, 3, 1};
    int         ewlk[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 0};
    logic [2:0] ph;
    int         len, wc;
    @(negedge clk);
    reset = 1'b1;
    req_ns = 1'b1; req_ew = 1'b1; req_ped = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      measure_run(ph, len, wc);
      checks++;
      if (ph !== eph[i] || len !== elen[i] || wc !== ewlk[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got phase %0d len %0d walk %0d, want phase %0d len %0d walk %0d",
                 i, ph, len, wc, eph[i], elen[i], ewlk[i]);
      end
    end
    checks++;
    if (phase !== P_NSG) begin
      errors++; $display("FAIL rr_wrap_ns: got phase %0d want %0d", phase, P_NSG);
    end
    req_ns = 1'b0; req_ew = 1'b0; req_ped = 1'b0;
  endtask

  task automatic test_conflict_ew();
    logic [2:0] eph [5] = '{P_SU, P_AR, P_NSG, P_NSY, P_AR};
    int         elen[5] = '{3, 1, 1, 2, 1};
    logic [2:0] ph;
    int         len, wc;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      measure_run(ph, len, wc);
      checks++;
      if (ph !== eph[i] || len !== elen[i]) begin
        errors++;
        $display("FAIL ew_pre[%0d]: got phase %0d len %0d, want phase %0d len %0d", i, ph, len, eph[i], elen[i]);
      end
    end
    req_ew = 1'b1;
    @(negedge clk);
    req_ew = 1'b0;
    checks++;
    if (pending !== 3'b010 || phase !== P_NSG) begin
      errors++; $display("FAIL ew_latch: got pending %b phase %0d, want 010 %0d", pending, phase, P_NSG);
    end
    for (int i = 2; i < 5; i++) begin
      measure_run(ph, len, wc);
      checks++;
      if (ph !== eph[i] || len !== elen[i]) begin
        errors++;
        $display("FAIL ew_seq[%0d]: got phase %0d len %0d, want phase %0d len %0d", i, ph, len, eph[i], elen[i]);
      end
    end
    checks++;
    if (phase !== P_EWG || pending !== 3'b000) begin
      errors++; $display("FAIL ew_entry: got phase %0d pending %b, want %0d 000", phase, pending, P_EWG);
    end
  endtask

  task automatic test_tick_freeze();
    logic [2:0] eph [3] = '{P_EWG, P_EWY, P_AR};
    int         elen[3] = '{1, 2, 1};
    logic [2:0] ph;
    int         len, wc;
    int         stable = 0;
    @(negedge clk);
    tick = 1'b0;
    req_ped = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_ped = 1'b0;
      if (phase === P_EWG && lights() === L_EWG) stable++;
    end
    checks++;
    if (stable !== 20) begin
      errors++; $display("FAIL freeze_hold: got %0d stable cycles want 20", stable);
    end
    checks++;
    if (pending !== 3'b100) begin
      errors++; $display("FAIL freeze_latch: got pending %b want 100", pending);
    end
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      measure_run(ph, len, wc);
      checks++;
      if (ph !== eph[i] || len !== elen[i]) begin
        errors++;
        $display("FAIL freeze_seq[%0d]: got phase %0d len %0d, want phase %0d len %0d", i, ph, len, eph[i], elen[i]);
      end
    end
    checks++;
    if (phase !== P_PED || pending !== 3'b000) begin
      errors++; $display("FAIL ped_entry: got phase %0d pending %b, want %0d 000", phase, pending, P_PED);
    end
  endtask

  task automatic test_reset_in_walk();
    req_ns = 1'b1;
    @(negedge clk);
    req_ns = 1'b0;
    checks++;
    if (pending !== 3'b001 || ped_walk !== 1'b1) begin
      errors++; $display("FAIL walk_pre: got pending %b walk %b, want 001 1", pending, ped_walk);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (lights() !== L_ALLRED || phase !== P_SU || pending !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got lights %b phase %0d pending %b, want %b %0d 000",
               lights(), phase, pending, L_ALLRED, P_SU);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick = 1'b1;
    req_ns = 1'b0; req_ew = 1'b0; req_ped = 1'b0;
    test_reset();
    test_no_requests();
    test_all_requests();
    test_conflict_ew();
    test_tick_freeze();
    test_reset_in_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
